// File: rtl/fetch_host_pkg.sv
// Shared constants and the held A-request record for the TL-UL fetch host.
package fetch_host_pkg;

  localparam int unsigned DefOutstanding = 2;
  localparam int unsigned TlSrcW         = 8;
  localparam logic [1:0]  FetchSize      = 2'd2;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Source ID width for the default build; the host derives its own from its parameter.
  localparam int unsigned SrcW = src_w(DefOutstanding);

  typedef struct packed {
    logic [31:0]       addr;
    logic [TlSrcW-1:0] source;
  } held_req_t;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types used by the fetch host: A channel plus d_ready, D channel plus a_ready.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/fetch_src_fifo.sv
// In-order FIFO of issued source IDs; pop data is combinational (bypasses push when empty).
// Zero-latency read; push while full is accepted only together with a pop.
module fetch_src_fifo
  import fetch_host_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = src_w(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [W-1:0]  mem [Depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          bypass, do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(Depth));
  assign bypass  = empty & push & pop;
  assign do_push = push & ~bypass & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? push_dat : mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/tlul_fetch_host.sv
// Core fetch -> TL-UL Get host; gnt->a_valid 1 cycle, D beat->rvalid 1 cycle, misaligned err 1 cycle after gnt.
// Gnt withheld while the A slot is busy or Outstanding Gets are in flight; FETCH_RSP_CHECK_EN adds D opcode/size checks.
module tlul_fetch_host
  import fetch_host_pkg::*;
#(
  parameter int unsigned Outstanding = DefOutstanding,
  parameter int unsigned AddrW       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [AddrW-1:0]  fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rvalid_o,
  output logic [31:0]       fetch_rdata_o,
  output logic              fetch_err_o,
  input  logic              flush_i,
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i
);

  localparam int unsigned SW = src_w(Outstanding);
  localparam int unsigned CW = $clog2(Outstanding + 1);

  held_req_t     held;
  logic          held_vld;
  logic [CW-1:0] out_cnt, disc_cnt, in_use;
  logic [SW-1:0] src_cnt, pop_id;
  logic          rvalid_q, err_q, mis_q;
  logic [31:0]   rdata_q;
  logic          aligned, a_fire, d_fire, rsp_err, src_full, src_empty;
  logic          unused_tl;

  assign aligned = (fetch_addr_i[1:0] == 2'b00);
  assign in_use  = out_cnt + CW'(held_vld);
  assign a_fire  = held_vld & tl_i.a_ready;
  // Beats with nothing in flight are stray and must not touch any count.
  assign d_fire  = tl_i.d_valid & (out_cnt != '0);

  assign fetch_gnt_o = ~rst_i & fetch_req_i & ~flush_i & ~held_vld &
                       (in_use < CW'(Outstanding)) & (aligned | (out_cnt == '0));

  always_comb begin
    rsp_err = tl_i.d_error | (tl_i.d_source != TlSrcW'(pop_id));
`ifdef FETCH_RSP_CHECK_EN
    rsp_err = rsp_err | (tl_i.d_opcode != tlul_pkg::AccessAckData) | (tl_i.d_size != FetchSize);
`endif
  end

  fetch_src_fifo #(
    .Depth (Outstanding),
    .W     (SW)
  ) u_src_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (a_fire),
    .push_dat (src_cnt),
    .pop      (d_fire),
    .pop_dat  (pop_id),
    .empty    (src_empty),
    .full     (src_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_vld <= 1'b0;
      held     <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
      src_cnt  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (fetch_gnt_o && aligned) begin
        held_vld    <= 1'b1;
        held.addr   <= 32'({fetch_addr_i[AddrW-1:2], 2'b00});
        held.source <= TlSrcW'(src_cnt);
      end else if (a_fire) begin
        held_vld <= 1'b0;
      end

      if (a_fire) src_cnt <= (src_cnt == SW'(Outstanding - 1)) ? '0 : src_cnt + 1'b1;
      out_cnt <= out_cnt + CW'(a_fire) - CW'(d_fire);

      // The held request cannot be retracted, so its response is discarded too.
      if (flush_i)                         disc_cnt <= in_use - CW'(d_fire);
      else if (d_fire && disc_cnt != '0)   disc_cnt <= disc_cnt - 1'b1;

      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      if (fetch_gnt_o && !aligned) begin
        rvalid_q <= 1'b1;
        rdata_q  <= '0;
        err_q    <= 1'b1;
        mis_q    <= 1'b1;
      end else if (d_fire && !flush_i && disc_cnt == '0) begin
        rvalid_q <= 1'b1;
        rdata_q  <= tl_i.d_data;
        err_q    <= rsp_err;
      end
    end
  end

  // A local misaligned error still pending when a flush lands is dropped.
  assign fetch_rvalid_o = rvalid_q & ~(mis_q & flush_i);
  assign fetch_rdata_o  = rdata_q;
  assign fetch_err_o    = err_q;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = held_vld;
    tl_o.a_opcode  = tlul_pkg::Get;
    tl_o.a_size    = FetchSize;
    tl_o.a_source  = held.source;
    tl_o.a_address = held.addr;
    tl_o.a_mask    = 4'hF;
    tl_o.d_ready   = 1'b1;
  end

  assign unused_tl = ^{tl_i.d_param, tl_i.d_sink, tl_i.d_opcode, tl_i.d_size, src_full, src_empty};

endmodule

// File: tb/tb_tlul_fetch_host.sv
// Bench for tlul_fetch_host: table of single fetches plus multi-cycle sequences, TL-UL device model, scoreboard.
module tb_tlul_fetch_host;
  import tlul_pkg::*;

`ifdef FETCH_RSP_CHECK_EN
  localparam logic OP_ERR = 1'b1;
`else
  localparam logic OP_ERR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_req_i = 1'b0;
  logic [31:0] fetch_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        fetch_gnt_o, fetch_rvalid_o, fetch_err_o;
  logic [31:0] fetch_rdata_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  logic        d_vld = 1'b0, d_err = 1'b0, a_rdy = 1'b1;
  logic [7:0]  d_src = '0;
  logic [31:0] d_dat = '0;
  tl_d_op_e    d_op = AccessAckData;

  always_comb begin
    tl_i          = '0;
    tl_i.d_valid  = d_vld;
    tl_i.d_opcode = d_op;
    tl_i.d_size   = 2'd2;
    tl_i.d_source = d_src;
    tl_i.d_data   = d_dat;
    tl_i.d_error  = d_err;
    tl_i.a_ready  = a_rdy;
  end

  tlul_fetch_host #(.Outstanding(2), .AddrW(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_req_i    (fetch_req_i),
    .fetch_addr_i   (fetch_addr_i),
    .fetch_gnt_o    (fetch_gnt_o),
    .fetch_rvalid_o (fetch_rvalid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_err_o    (fetch_err_o),
    .flush_i        (flush_i),
    .tl_o           (tl_o),
    .tl_i           (tl_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int av_cnt = 0, rv_cnt = 0;
  int src_model = 0;
  int dev_lat = 1;
  logic dev_hold = 1'b0;

  typedef struct { logic [31:0] data; logic err; int at; } exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] src; } aexp_t;
  typedef struct { logic [31:0] data; logic err; logic bsrc; tl_d_op_e op; } drsp_t;
  typedef struct {
    logic [31:0] addr; logic [31:0] rdat; logic rerr; logic bsrc; tl_d_op_e op;
    logic [31:0] xdat; logic xerr;
  } vec_t;

  exp_t  exp_q[$];
  aexp_t a_exp_q[$];
  drsp_t dev_rsp_q[$];
  logic [7:0] pend_src[$];
  int         pend_t[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (tl_o.a_valid) av_cnt++;
      if (fetch_rvalid_o) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid actual rdata=%0h err=%0b required=no response", fetch_rdata_o, fetch_err_o);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", fetch_rdata_o, e.data);
          chk("rerr", fetch_err_o, e.err);
          if (e.at >= 0) chk("rsp_cycle", cyc, e.at);
        end
      end
    end
  end

  // TL-UL device: checks A fields, answers in order after dev_lat cycles unless held.
  initial begin
    aexp_t ae;
    drsp_t r;
    logic [7:0] s;
    forever begin
      @(negedge clk_i);
      if (tl_o.a_valid && a_rdy) begin
        if (a_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_a actual addr=%0h required=no request", tl_o.a_address);
        end else begin
          ae = a_exp_q.pop_front();
          chk("a_address", tl_o.a_address, ae.addr);
          chk("a_source", tl_o.a_source, ae.src);
          chk("a_mask", tl_o.a_mask, 4'hF);
          chk("a_op_size", {tl_o.a_opcode, tl_o.a_size}, {Get, 2'd2});
        end
        pend_src.push_back(tl_o.a_source);
        pend_t.push_back(cyc + dev_lat);
      end
      @(posedge clk_i);
      #1;
      d_vld = 1'b0;
      if (!dev_hold && pend_src.size() > 0 && cyc >= pend_t[0]) begin
        s = pend_src.pop_front();
        void'(pend_t.pop_front());
        r = (dev_rsp_q.size() > 0) ? dev_rsp_q.pop_front() : '{32'h0, 1'b0, 1'b0, AccessAckData};
        d_vld = 1'b1;
        d_src = r.bsrc ? (s ^ 8'h01) : s;
        d_dat = r.data;
        d_err = r.err;
        d_op  = r.op;
      end
    end
  end

  // Called right after a posedge; returns right after a posedge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdat, input logic rerr,
                       input logic bsrc, input tl_d_op_e op, input logic expect_rsp,
                       input logic [31:0] xdat, input logic xerr, input int lat);
    int n = 0;
    logic got = 1'b0;
    fetch_req_i  = 1'b1;
    fetch_addr_i = addr;
    while (!got && n < 100) begin
      @(negedge clk_i);
      if (fetch_gnt_o) got = 1'b1;
      else n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout addr=%0h actual gnt=0 required=1", addr);
    end else begin
      if (addr[1:0] == 2'b00) begin
        a_exp_q.push_back('{{addr[31:2], 2'b00}, 8'(src_model)});
        src_model = (src_model + 1) % 2;
        dev_rsp_q.push_back('{rdat, rerr, bsrc, op});
      end
      if (expect_rsp) exp_q.push_back('{xdat, xerr, (lat > 0) ? cyc + lat : -1});
    end
    @(posedge clk_i);
    #1;
    fetch_req_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend_src.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual pending=%0d required=0", name, exp_q.size() + pend_src.size());
    end
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];
  int av0, rv0;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0, AccessAckData, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0200, 32'h1234_5678, 1'b1, 1'b0, AccessAckData, 32'h1234_5678, 1'b1};
    vecs[2] = '{32'h0000_0204, 32'hCAFE_F00D, 1'b0, 1'b1, AccessAckData, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{32'h0000_0102, 32'h0,         1'b0, 1'b0, AccessAckData, 32'h0,         1'b1};
    vecs[4] = '{32'h0000_0208, 32'h0BAD_0208, 1'b0, 1'b0, AccessAck,     32'h0BAD_0208, OP_ERR};
    vecs[5] = '{32'h0000_020C, 32'h0000_0000, 1'b0, 1'b0, AccessAckData, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'h0000_0301, 32'h0,         1'b0, 1'b0, AccessAckData, 32'h0,         1'b1};
    vecs[7] = '{32'h0000_03FC, 32'hFFFF_FFFF, 1'b0, 1'b0, AccessAckData, 32'hFFFF_FFFF, 1'b0};

    // Reset state, with a request pending to show gnt stays low.
    fetch_req_i = 1'b1;
    tick(2);
    @(negedge clk_i);
    chk("rst_gnt", fetch_gnt_o, 1'b0);
    chk("rst_a_valid", tl_o.a_valid, 1'b0);
    chk("rst_rvalid", fetch_rvalid_o, 1'b0);
    chk("rst_rdata", fetch_rdata_o, 32'h0);
    chk("rst_err", fetch_err_o, 1'b0);
    chk("d_ready", tl_o.d_ready, 1'b1);
    @(posedge clk_i);
    #1;
    fetch_req_i = 1'b0;
    rst_i = 1'b0;
    tick(2);

    for (int i = 0; i < 8; i++) begin
      av0 = av_cnt;
      fetch(vecs[i].addr, vecs[i].rdat, vecs[i].rerr, vecs[i].bsrc, vecs[i].op, 1'b1,
            vecs[i].xdat, vecs[i].xerr, (vecs[i].addr[1:0] == 2'b00) ? 3 : 1);
      wait_idle("vec");
      if (vecs[i].addr[1:0] != 2'b00) chk("mis_no_a_valid", av_cnt - av0, 0);
    end

    // Back-to-back with D stalled: third gnt waits for the first beat; sources 0,1,0.
    dev_hold = 1'b1;
    fetch(32'h0, 32'hA0A0_0000, 1'b0, 1'b0, AccessAckData, 1'b1, 32'hA0A0_0000, 1'b0, -1);
    fetch(32'h4, 32'hA0A0_0004, 1'b0, 1'b0, AccessAckData, 1'b1, 32'hA0A0_0004, 1'b0, -1);
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h8;
    repeat (4) begin
      @(negedge clk_i);
      chk("gnt_blocked_full", fetch_gnt_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    dev_hold = 1'b0;
    fetch(32'h8, 32'hA0A0_0008, 1'b0, 1'b0, AccessAckData, 1'b1, 32'hA0A0_0008, 1'b0, -1);
    wait_idle("b2b");

    // Misaligned fetch must wait until nothing is in flight.
    dev_hold = 1'b1;
    fetch(32'h600, 32'h0000_0600, 1'b0, 1'b0, AccessAckData, 1'b1, 32'h0000_0600, 1'b0, -1);
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h602;
    repeat (3) begin
      @(negedge clk_i);
      chk("mis_blocked", fetch_gnt_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    dev_hold = 1'b0;
    fetch(32'h602, 32'h0, 1'b0, 1'b0, AccessAckData, 1'b1, 32'h0, 1'b1, 1);
    wait_idle("mis_wait");

    // A channel stall: request held stable until a_ready.
    a_rdy = 1'b0;
    fetch(32'h500, 32'h0000_5555, 1'b0, 1'b0, AccessAckData, 1'b1, 32'h0000_5555, 1'b0, -1);
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_a_valid", tl_o.a_valid, 1'b1);
      chk("stall_a_addr", tl_o.a_address, 32'h500);
    end
    @(posedge clk_i);
    #1;
    a_rdy = 1'b1;
    wait_idle("stall");

    // Flush with two Gets in flight, then a fresh fetch.
    dev_hold = 1'b1;
    fetch(32'h10, 32'hBAD0_0010, 1'b0, 1'b0, AccessAckData, 1'b0, 32'h0, 1'b0, -1);
    fetch(32'h14, 32'hBAD0_0014, 1'b0, 1'b0, AccessAckData, 1'b0, 32'h0, 1'b0, -1);
    tick(2);
    rv0 = rv_cnt;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i  = 1'b0;
    dev_hold = 1'b0;
    fetch(32'h40, 32'h4040_4040, 1'b0, 1'b0, AccessAckData, 1'b1, 32'h4040_4040, 1'b0, -1);
    wait_idle("flush2");
    chk("flush2_rsp_count", rv_cnt - rv0, 1);

    // Flush with one Get in flight and a request present: no gnt in the flush cycle.
    dev_hold = 1'b1;
    fetch(32'h50, 32'hBAD0_0050, 1'b0, 1'b0, AccessAckData, 1'b0, 32'h0, 1'b0, -1);
    tick(1);
    rv0 = rv_cnt;
    flush_i      = 1'b1;
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h54;
    @(negedge clk_i);
    chk("gnt_in_flush", fetch_gnt_o, 1'b0);
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    fetch_req_i = 1'b0;
    dev_hold    = 1'b0;
    wait_idle("flush1");
    chk("flush1_rsp_count", rv_cnt - rv0, 0);

    // Reset with two Gets outstanding, then a stray D beat.
    dev_hold = 1'b1;
    fetch(32'h700, 32'hBAD0_0700, 1'b0, 1'b0, AccessAckData, 1'b0, 32'h0, 1'b0, -1);
    fetch(32'h704, 32'hBAD0_0704, 1'b0, 1'b0, AccessAckData, 1'b0, 32'h0, 1'b0, -1);
    tick(2);
    rst_i = 1'b1;
    tick(2);
    @(negedge clk_i);
    chk("mid_rst_a_valid", tl_o.a_valid, 1'b0);
    chk("mid_rst_rvalid", fetch_rvalid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    pend_src.delete();
    pend_t.delete();
    dev_rsp_q.delete();
    a_exp_q.delete();
    src_model = 0;
    rv0 = rv_cnt;
    pend_src.push_back(8'h00);
    pend_t.push_back(0);
    dev_rsp_q.push_back('{32'h57A7_57A7, 1'b0, 1'b0, AccessAckData});
    dev_hold = 1'b0;
    tick(4);
    @(negedge clk_i);
    chk("stray_rsp_count", rv_cnt - rv0, 0);
    chk("stray_rdata", fetch_rdata_o, 32'h0);
    chk("stray_err", fetch_err_o, 1'b0);
    chk("stray_a_valid", tl_o.a_valid, 1'b0);
    @(posedge clk_i);
    #1;
    fetch(32'h800, 32'h0000_0888, 1'b0, 1'b0, AccessAckData, 1'b1, 32'h0000_0888, 1'b0, 3);
    wait_idle("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
